elevator_controller: RTL and testbench

Three-floor elevator control FSM. It sits behind the frequency divider and consumes the divided `clk` together with the panel inputs: SOS button, weight sensor, and the three floor buttons. It latches floor requests, schedules car movement, times the door, handles overload and emergency, and drives every panel LED.

---
 rtl/elevator_pkg.sv | 43 ++++
 rtl/elevator_controller_floor_request_latch.sv | 30 +++
 rtl/elevator_controller.sv | 155 +++++++++++++++
 tb/tb_elevator_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the three-floor elevator controller.
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MOVING,
      DOOR_OPEN,
      EMERGENCY
   } state_t;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

   localparam logic [1:0] FLOOR_1 = 2'd0;
   localparam logic [1:0] FLOOR_2 = 2'd1;
   localparam logic [1:0] FLOOR_3 = 2'd2;

   function automatic logic [2:0] floor_mask(
      input logic [1:0] f
   );
      floor_mask = 3'b001 << f;
   endfunction

   // Any pending request strictly past floor f when travelling in d.
   function automatic logic req_beyond(
      input logic [2:0] p,
      input logic [1:0] f,
      input dir_t       d
   );
      logic r;
      r = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (p[i]) begin
            if (d == UP && 2'(i) > f) r = 1'b1;
            if (d == DOWN && 2'(i) < f) r = 1'b1;
         end
      end
      req_beyond = r;
   endfunction

endpackage

// File: rtl/elevator_controller_floor_request_latch.sv
// Sticky per-floor request bits; a clear of the same bit wins over a set.
module floor_request_latch (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] set_req,
   input  logic [1:0] clr_idx,
   input  logic       clr_en,
   input  logic       clr_all,
   input  logic       ignore_req,
   output logic [2:0] pending
);
   import elevator_pkg::*;

   logic [2:0] clr_mask;
   logic [2:0] pending_nx;

   always_comb begin
      clr_mask   = clr_en ? floor_mask(clr_idx) : 3'b000;
      pending_nx = pending;
      if (!ignore_req) pending_nx = pending_nx | set_req;
      pending_nx = pending_nx & ~clr_mask;
      if (clr_all) pending_nx = 3'b000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= 3'b000;
      else        pending <= pending_nx;
   end

endmodule

// File: rtl/elevator_controller.sv
// Three-floor car scheduler: request latching, travel and door timing,
// overload hold and SOS emergency, with fully registered panel LEDs.
module elevator_controller #(
   parameter int unsigned MOVE_TICKS = 3,
   parameter int unsigned DOOR_TICKS = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sos_button,
   input  logic weight_sensor,
   input  logic st_floor_button,
   input  logic nd_floor_button,
   input  logic rd_floor_button,
   output logic sos_led,
   output logic weight_led,
   output logic emergency_led,
   output logic st_floor_led,
   output logic nd_floor_led,
   output logic rd_floor_led,
   output logic door_status_led
);
   import elevator_pkg::*;

   localparam logic [7:0] MOVE_LAST = 8'(MOVE_TICKS - 1);
   localparam logic [7:0] DOOR_LAST = 8'(DOOR_TICKS - 1);

   state_t     state, state_nx;
   dir_t       dir, dir_nx;
   logic [1:0] floor, floor_nx, step_floor;
   logic [7:0] cnt, cnt_nx;
   logic       sos_d, sos_rise, can_step;
   logic [2:0] pending, buttons, set_req;
   logic [1:0] clr_idx;
   logic       clr_en, clr_all, ignore_req;

   assign buttons  = {rd_floor_button, nd_floor_button,
                      st_floor_button};
   assign sos_rise = sos_led & ~sos_d;

   floor_request_latch u_latch (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_req    (set_req),
      .clr_idx    (clr_idx),
      .clr_en     (clr_en),
      .clr_all    (clr_all),
      .ignore_req (ignore_req),
      .pending    (pending)
   );

   always_comb begin
      state_nx   = state;
      dir_nx     = dir;
      floor_nx   = floor;
      cnt_nx     = cnt;
      clr_idx    = floor;
      clr_en     = 1'b0;
      clr_all    = 1'b0;
      ignore_req = (state == EMERGENCY);
      set_req    = buttons;
      if (state == DOOR_OPEN)
         set_req = buttons & ~floor_mask(floor);
      step_floor = (dir == UP) ? floor + 2'd1 : floor - 2'd1;
      can_step   = (dir == UP) ? (floor != FLOOR_3)
                               : (floor != FLOOR_1);
      if (sos_rise && state != EMERGENCY) begin
         state_nx = EMERGENCY;
         cnt_nx   = 8'd0;
         clr_all  = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (pending[floor]) begin
                  state_nx = DOOR_OPEN;
                  clr_en   = 1'b1;
                  cnt_nx   = 8'd0;
               end else if (req_beyond(pending, floor, dir)) begin
                  state_nx = MOVING;
                  cnt_nx   = 8'd0;
               end else if (req_beyond(pending, floor,
                                       dir == UP ? DOWN : UP)) begin
                  dir_nx   = (dir == UP) ? DOWN : UP;
                  state_nx = MOVING;
                  cnt_nx   = 8'd0;
               end
            end
            MOVING: begin
               cnt_nx = cnt + 8'd1;
               if (cnt >= MOVE_LAST) begin
                  cnt_nx = 8'd0;
                  if (!can_step) begin
                     state_nx = IDLE;
                  end else begin
                     floor_nx = step_floor;
                     clr_idx  = step_floor;
                     if (pending[step_floor]) begin
                        state_nx = DOOR_OPEN;
                        clr_en   = 1'b1;
                     end else if (!req_beyond(pending, step_floor,
                                              dir)) begin
                        state_nx = IDLE;
                     end
                  end
               end
            end
            DOOR_OPEN: begin
               cnt_nx = cnt + 8'd1;
               if (buttons[floor]) begin
                  cnt_nx = 8'd0;
               end else if (cnt >= DOOR_LAST) begin
                  cnt_nx = 8'd0;
                  if (!weight_sensor) state_nx = IDLE;
               end
            end
            EMERGENCY: begin
               cnt_nx = 8'd0;
               if (sos_rise) state_nx = DOOR_OPEN;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // LEDs are computed from next-state so they change on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         dir             <= UP;
         floor           <= FLOOR_1;
         cnt             <= 8'd0;
         sos_d           <= 1'b0;
         sos_led         <= 1'b0;
         weight_led      <= 1'b0;
         emergency_led   <= 1'b0;
         st_floor_led    <= 1'b1;
         nd_floor_led    <= 1'b0;
         rd_floor_led    <= 1'b0;
         door_status_led <= 1'b0;
      end else begin
         state           <= state_nx;
         dir             <= dir_nx;
         floor           <= floor_nx;
         cnt             <= cnt_nx;
         sos_d           <= sos_led;
         sos_led         <= sos_button;
         weight_led      <= (state_nx == DOOR_OPEN) & weight_sensor;
         emergency_led   <= (state_nx == EMERGENCY);
         {rd_floor_led, nd_floor_led, st_floor_led}
                         <= floor_mask(floor_nx);
         door_status_led <= (state_nx == DOOR_OPEN) ||
                            (state_nx == EMERGENCY);
      end
   end

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller: expectations are queued
// with a target edge number when stimulus is driven.
module tb_elevator_controller;

   localparam logic [6:0] SOS = 7'b1000000;
   localparam logic [6:0] W   = 7'b0100000;
   localparam logic [6:0] EM  = 7'b0010000;
   localparam logic [6:0] RD  = 7'b0001000;
   localparam logic [6:0] ND  = 7'b0000100;
   localparam logic [6:0] ST  = 7'b0000010;
   localparam logic [6:0] D   = 7'b0000001;

   typedef struct {
      string      tag;
      int         at;
      bit         kind;
      logic [6:0] exp;
   } sb_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic sos_button = 1'b0;
   logic weight_sensor = 1'b0;
   logic st_b = 1'b0;
   logic nd_b = 1'b0;
   logic rd_b = 1'b0;
   logic sos_led, weight_led, emergency_led;
   logic st_led, nd_led, rd_led, door_led;
   logic [6:0] o;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n;
   sb_t  sb[$];

   elevator_controller #(
      .MOVE_TICKS (3),
      .DOOR_TICKS (5)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sos_button      (sos_button),
      .weight_sensor   (weight_sensor),
      .st_floor_button (st_b),
      .nd_floor_button (nd_b),
      .rd_floor_button (rd_b),
      .sos_led         (sos_led),
      .weight_led      (weight_led),
      .emergency_led   (emergency_led),
      .st_floor_led    (st_led),
      .nd_floor_led    (nd_led),
      .rd_floor_led    (rd_led),
      .door_status_led (door_led)
   );

   assign o = {sos_led, weight_led, emergency_led,
               rd_led, nd_led, st_led, door_led};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [6:0] obs,
                      input logic [6:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int at,
                       input bit kind, input logic [6:0] exp);
      sb_t e;
      e.tag  = tag;
      e.at   = at;
      e.kind = kind;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc) begin
            if (sb[i].kind)
               chk(sb[i].tag, {4'b0, dut.pending}, sb[i].exp);
            else
               chk(sb[i].tag, o, sb[i].exp);
            sb.delete(i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: no finish by time limit");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state and quiet idle
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out", o, ST);
      chk("rst_pend", {4'b0, dut.pending}, 7'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 1; k <= 20; k++)
         push("idle_quiet", cyc + k, 1'b0, ST);
      wait_cyc(cyc + 21);

      // floor 1 -> 3, one-cycle pulse
      n = cyc + 1;
      rd_b = 1'b1;
      push("up_f1_hold", n + 3, 1'b0, ST);
      push("up_f2", n + 4, 1'b0, ND);
      push("up_f2_mov", n + 6, 1'b0, ND);
      push("up_f3_door", n + 7, 1'b0, RD | D);
      push("up_door_end", n + 11, 1'b0, RD | D);
      push("up_closed", n + 12, 1'b0, RD);
      push("up_pend0", n + 13, 1'b1, 7'd0);
      wait_cyc(n);
      rd_b = 1'b0;
      wait_cyc(n + 14);

      // overload at open door on floor 3
      n = cyc + 1;
      rd_b = 1'b1;
      push("ov_open", n + 1, 1'b0, RD | D);
      for (int k = 2; k <= 13; k++)
         push("ov_hold", n + k, 1'b0, RD | W | D);
      push("ov_rel1", n + 14, 1'b0, RD | D);
      push("ov_rel2", n + 15, 1'b0, RD | D);
      push("ov_closed", n + 16, 1'b0, RD);
      wait_cyc(n);
      rd_b = 1'b0;
      wait_cyc(n + 1);
      weight_sensor = 1'b1;
      wait_cyc(n + 13);
      weight_sensor = 1'b0;
      wait_cyc(n + 17);

      // floor 3 -> 1, passing floor 2
      n = cyc + 1;
      st_b = 1'b1;
      push("dn_f2", n + 4, 1'b0, ND);
      push("dn_f1_door", n + 7, 1'b0, ST | D);
      push("dn_closed", n + 12, 1'b0, ST);
      wait_cyc(n);
      st_b = 1'b0;
      wait_cyc(n + 13);

      // at floor 2 going up with 1 and 3 pending
      n = cyc + 1;
      rd_b = 1'b1;
      push("dir_f2", n + 4, 1'b0, ND);
      push("dir_f3_first", n + 7, 1'b0, RD | D);
      push("dir_pend_f1", n + 8, 1'b1, 7'b0000001);
      push("dir_f3_closed", n + 12, 1'b0, RD);
      push("dir_flip_mov", n + 13, 1'b0, RD);
      push("dir_back_f2", n + 16, 1'b0, ND);
      push("dir_f1_door", n + 19, 1'b0, ST | D);
      push("dir_pend0", n + 20, 1'b1, 7'd0);
      push("dir_closed", n + 24, 1'b0, ST);
      wait_cyc(n);
      rd_b = 1'b0;
      wait_cyc(n + 4);
      st_b = 1'b1;
      wait_cyc(n + 5);
      st_b = 1'b0;
      wait_cyc(n + 25);

      // SOS during travel floor 1 -> 3
      n = cyc + 1;
      rd_b = 1'b1;
      push("sos_f2", n + 4, 1'b0, ND);
      push("sos_reg", n + 6, 1'b0, SOS | ND);
      push("sos_emerg", n + 7, 1'b0, SOS | EM | ND | D);
      push("sos_pend_clr", n + 7, 1'b1, 7'd0);
      push("sos_hold", n + 9, 1'b0, EM | ND | D);
      push("sos_btn_ign", n + 11, 1'b1, 7'd0);
      push("sos_2nd_reg", n + 13, 1'b0, SOS | EM | ND | D);
      push("sos_exit", n + 14, 1'b0, SOS | ND | D);
      push("sos_door_end", n + 18, 1'b0, ND | D);
      push("sos_idle", n + 19, 1'b0, ND);
      push("sos_pend0", n + 19, 1'b1, 7'd0);
      wait_cyc(n);
      rd_b = 1'b0;
      wait_cyc(n + 5);
      sos_button = 1'b1;
      wait_cyc(n + 8);
      sos_button = 1'b0;
      st_b = 1'b1;
      wait_cyc(n + 10);
      st_b = 1'b0;
      wait_cyc(n + 12);
      sos_button = 1'b1;
      wait_cyc(n + 14);
      sos_button = 1'b0;
      wait_cyc(n + 20);

      // asynchronous reset in the middle of travel
      n = cyc + 1;
      rd_b = 1'b1;
      wait_cyc(n);
      rd_b = 1'b0;
      wait_cyc(n + 2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out", o, ST);
      chk("arst_pend", {4'b0, dut.pending}, 7'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 1; k <= 3; k++)
         push("arst_after", cyc + k, 1'b0, ST);
      wait_cyc(cyc + 4);

      chk("sb_drain", 7'(sb.size()), 7'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
